// File: rtl/alu_seq_ctrl_if.sv
// Bundle of instruction, register-file, ALU and completion signals for alu_seq_ctrl.
// The retired_cnt signal exists only when ALU_SEQ_PERF_EN is defined.
interface alu_seq_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [4:0]        rf_rs_addr;
    logic [4:0]        rf_rt_addr;
    logic [5:0]        alu_funct;
    logic [4:0]        alu_shamt;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_zero;
    logic              res_carry;
    logic              res_err;
    logic              busy;
`ifdef ALU_SEQ_PERF_EN
    logic [CNT_W-1:0]  retired_cnt;
`endif

    // Controller side
    modport slave (
        input  instr_valid, instr, alu_result, alu_zero, alu_carry, res_ready,
        output instr_ready, rf_rs_addr, rf_rt_addr, alu_funct, alu_shamt,
               rf_we, rf_waddr, rf_wdata, res_valid, res_data, res_zero,
               res_carry, res_err, busy
`ifdef ALU_SEQ_PERF_EN
        , output retired_cnt
`endif
    );

    // Instruction producer / ALU / consumer side
    modport master (
        output instr_valid, instr, alu_result, alu_zero, alu_carry, res_ready,
        input  instr_ready, rf_rs_addr, rf_rt_addr, alu_funct, alu_shamt,
               rf_we, rf_waddr, rf_wdata, res_valid, res_data, res_zero,
               res_carry, res_err, busy
`ifdef ALU_SEQ_PERF_EN
        , input retired_cnt
`endif
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Five-state sequencer for one R-type instruction at a time: read, execute, write back, respond.
// Optional retired-instruction counter enabled by defining ALU_SEQ_PERF_EN.
module alu_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RESP} state_e;

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
    logic              res_carry_q, res_carry_d;
    logic              res_err_q, res_err_d;
    logic              op_ok;
    logic [4:0]        rd;

    if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("alu_seq_ctrl: DATA_W and CNT_W must be positive");
    end

    assign op_ok = (instr_q[31:26] == 6'd0);
    assign rd    = instr_q[15:11];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_carry_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_carry_q <= res_carry_d;
            res_err_q   <= res_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_carry_d = res_carry_q;
        res_err_d   = res_err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = READ;
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
                // Rejected opcodes still walk the full sequence with a zeroed record
                if (op_ok) begin
                    res_data_d  = bus.alu_result;
                    res_zero_d  = bus.alu_zero;
                    res_carry_d = bus.alu_carry;
                    res_err_d   = 1'b0;
                end else begin
                    res_data_d  = '0;
                    res_zero_d  = 1'b0;
                    res_carry_d = 1'b0;
                    res_err_d   = 1'b1;
                end
                state_d = WB;
            end
            WB:   state_d = RESP;
            RESP: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.rf_rs_addr  = instr_q[25:21];
    assign bus.rf_rt_addr  = instr_q[20:16];
    assign bus.alu_shamt   = instr_q[10:6];
    assign bus.alu_funct   = instr_q[5:0];
    // Decoded from state so an asynchronous reset drops the pulse immediately
    assign bus.rf_we       = (state_q == WB) && op_ok && (rd != 5'd0);
    assign bus.rf_waddr    = rd;
    assign bus.rf_wdata    = res_data_q;
    assign bus.res_valid   = (state_q == RESP);
    assign bus.res_data    = res_data_q;
    assign bus.res_zero    = res_zero_q;
    assign bus.res_carry   = res_carry_q;
    assign bus.res_err     = res_err_q;

`ifdef ALU_SEQ_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == RESP && bus.res_ready && !res_err_q) cnt_d = cnt_q + CNT_W'(1);
    end

    assign bus.retired_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl; counter checks run when ALU_SEQ_PERF_EN is defined.
module tb_alu_seq_ctrl;
`ifdef ALU_SEQ_PERF_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 16;
`endif

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic        zero;
        logic        carry;
        logic        err;
    } rec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    rec_t sb_q[$];
    int   exp_cnt;

    alu_seq_ctrl_if #(.DATA_W(32), .CNT_W(TB_CNT_W)) ifc ();

    alu_seq_ctrl #(.DATA_W(32), .CNT_W(TB_CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt();
`ifdef ALU_SEQ_PERF_EN
        check("retired_cnt", 32'(ifc.retired_cnt), 32'(exp_cnt));
`endif
    endtask

    // Drive one instruction with constant ALU outputs and follow it to completion.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] res,
                             input logic z, input logic c, input int hold, input bit offer2);
        rec_t e;
        rec_t got;
        int   w;
        e.err   = (ins[31:26] != 6'd0);
        e.waddr = ins[15:11];
        e.we    = !e.err && (ins[15:11] != 5'd0);
        e.data  = e.err ? 32'd0 : res;
        e.zero  = e.err ? 1'b0 : z;
        e.carry = e.err ? 1'b0 : c;
        sb_q.push_back(e);

        ifc.alu_result = res;
        ifc.alu_zero   = z;
        ifc.alu_carry  = c;
        ifc.res_ready  = 1'b0;
        w = 0;
        while (ifc.instr_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("instr_ready_wait", 32'(ifc.instr_ready), 32'd1);
        ifc.instr       = ins;
        ifc.instr_valid = 1'b1;

        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ifc.instr_valid = 1'b0;
                ifc.instr       = 32'hDEAD_BEEF;
                check("rs_addr", 32'(ifc.rf_rs_addr), 32'(ins[25:21]));
                check("rt_addr", 32'(ifc.rf_rt_addr), 32'(ins[20:16]));
                check("funct",   32'(ifc.alu_funct),  32'(ins[5:0]));
                check("shamt",   32'(ifc.alu_shamt),  32'(ins[10:6]));
                check("busy",    32'(ifc.busy),       32'd1);
            end
            check($sformatf("rf_we_k%0d", k), 32'(ifc.rf_we), 32'((k == 3) && sb_q[0].we));
            check($sformatf("res_valid_k%0d", k), 32'(ifc.res_valid), 32'(k == 4));
            if (k == 3 && sb_q[0].we) begin
                check("rf_waddr", 32'(ifc.rf_waddr), 32'(sb_q[0].waddr));
                check("rf_wdata", ifc.rf_wdata, sb_q[0].data);
            end
        end

        got = sb_q.pop_front();
        check("res_data",  ifc.res_data,         got.data);
        check("res_zero",  32'(ifc.res_zero),    32'(got.zero));
        check("res_carry", 32'(ifc.res_carry),   32'(got.carry));
        check("res_err",   32'(ifc.res_err),     32'(got.err));

        if (offer2) begin
            ifc.instr       = 32'h0021_1820;
            ifc.instr_valid = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(ifc.res_valid),   32'd1);
            check("hold_ready", 32'(ifc.instr_ready), 32'd0);
            check("hold_data",  ifc.res_data,         got.data);
            check("hold_rs",    32'(ifc.rf_rs_addr),  32'(ins[25:21]));
        end
        ifc.instr_valid = 1'b0;
        ifc.res_ready   = 1'b1;
        @(negedge clk);
        ifc.res_ready = 1'b0;
        if (!got.err) exp_cnt = (exp_cnt + 1) % (1 << TB_CNT_W);
        check("post_valid", 32'(ifc.res_valid),   32'd0);
        check("post_ready", 32'(ifc.instr_ready), 32'd1);
        check_cnt();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        rst_n           = 1'b0;
        ifc.instr_valid = 1'b0;
        ifc.instr       = '0;
        ifc.alu_result  = '0;
        ifc.alu_zero    = 1'b0;
        ifc.alu_carry   = 1'b0;
        ifc.res_ready   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready",     32'(ifc.instr_ready), 32'd1);
        check("rst_busy",      32'(ifc.busy),        32'd0);
        check("rst_res_valid", 32'(ifc.res_valid),   32'd0);
        check("rst_rf_we",     32'(ifc.rf_we),       32'd0);
        check("rst_res_data",  ifc.res_data,         32'd0);
        check("rst_res_err",   32'(ifc.res_err),     32'd0);
        check("rst_rs_addr",   32'(ifc.rf_rs_addr),  32'd0);
        check_cnt();
        rst_n = 1'b1;
        @(negedge clk);
        check("release_ready", 32'(ifc.instr_ready), 32'd1);

        run_instr(32'h0022_1820, 32'h0000_0005, 1'b0, 1'b0, 0, 1'b0);
        run_instr(32'h0022_0020, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 1'b0);
        run_instr(32'h8C22_1820, 32'h0000_1234, 1'b1, 1'b1, 0, 1'b0);
        run_instr(32'h0043_1022, 32'h0000_0000, 1'b1, 1'b0, 10, 1'b1);
        run_instr(32'h0001_2900, 32'h0000_0080, 1'b0, 1'b0, 0, 1'b0);

        // Abort a sequence during write-back
        ifc.alu_result  = 32'h0000_0077;
        ifc.instr       = 32'h0022_2020;
        ifc.instr_valid = 1'b1;
        @(negedge clk);
        ifc.instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_we_before", 32'(ifc.rf_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we_async", 32'(ifc.rf_we),       32'd0);
        check("abort_busy",     32'(ifc.busy),        32'd0);
        check("abort_ready",    32'(ifc.instr_ready), 32'd1);
        check("abort_data",     ifc.res_data,         32'd0);
        exp_cnt = 0;
        check_cnt();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(ifc.res_valid), 32'd0);
        end
        check("abort_ready_after", 32'(ifc.instr_ready), 32'd1);

`ifdef ALU_SEQ_PERF_EN
        for (int n = 0; n < 17; n++) begin
            run_instr(32'h0022_1820 | 32'(n), 32'(n), 1'b0, 1'b0, 0, 1'b0);
        end
        check("cnt_after_17", 32'(ifc.retired_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, datapath width of source operands, result and write data.
REQ-002 Parameter: CNT_W, 16, width of retired-instruction counter (used only when ALU_SEQ_PERF_EN defined).
REQ-003 Ports:
- clk  input  1  sole clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  controller can accept instruction
- instr  input  32  R-type word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
- rf_rs_addr  output  5  register-file read address 1
- rf_rt_addr  output  5  register-file read address 2
- alu_funct  output  6  ALU operation select
- alu_shamt  output  5  ALU shift amount
- alu_result  input  DATA_W  ALU result
- alu_zero  input  1  ALU zero flag
- alu_carry  input  1  ALU carry flag
- rf_we  output  1  register-file write enable, one-cycle pulse
- rf_waddr  output  5  register-file write address
- rf_wdata  output  DATA_W  register-file write data
- res_valid  output  1  completion record valid
- res_ready  input  1  consumer accepts completion record
- res_data  output  DATA_W  captured result
- res_zero  output  1  captured zero flag
- res_carry  output  1  captured carry flag
- res_err  output  1  instruction rejected (opcode not 000000)
- busy  output  1  FSM not in IDLE
- retired_cnt  output  CNT_W  retired count (ALU_SEQ_PERF_EN only)

Function
REQ-004 FSM states IDLE, READ, EXEC, WB, RESP; exactly one active.
REQ-005 instr_ready = 1 only in IDLE; handshake = instr_valid & instr_ready; on handshake instr latched into internal instruction register, IDLE->READ.
REQ-006 rf_rs_addr, rf_rt_addr, alu_funct, alu_shamt driven combinationally from latched instruction register; stable from READ through WB.
REQ-007 READ: one cycle for RF read and ALU settle; READ->EXEC unconditionally.
REQ-008 EXEC: alu_result, alu_zero, alu_carry captured into res_data/res_zero/res_carry at end of cycle; EXEC->WB.
REQ-009 WB: rf_we = 1 for exactly this cycle, rf_waddr = latched rd, rf_wdata = res_data; WB->RESP.
REQ-010 rd = 0: rf_we held 0 in WB (register 0 never written); completion record still produced.
REQ-011 Opcode != 0: res_err = 1, rf_we held 0, res_data/res_zero/res_carry = 0; sequence still passes READ/EXEC/WB/RESP.
REQ-012 RESP: res_valid = 1, record held stable until res_valid & res_ready; then RESP->IDLE; res_valid deasserts next cycle.
REQ-013 Latency: handshake in cycle N -> rf_we pulse in N+3 -> res_valid first high in N+4; back-to-back throughput one instruction per 5 cycles when res_ready tied high.
REQ-014 instr_valid ignored outside IDLE; no instruction queued or dropped silently—producer holds until instr_ready.
REQ-015 busy = (state != IDLE).

Reset
REQ-016 rst_n low asynchronously forces IDLE, clears instruction register, res_data, res_zero, res_carry, res_err, res_valid, rf_we, retired_cnt to 0.
REQ-017 Reset asserted mid-sequence (including during WB) aborts: rf_we deasserts immediately, no completion record emitted after release.
REQ-018 After rst_n release, instr_ready = 1 on the first clock edge.

Configuration
REQ-019 Macro ALU_SEQ_PERF_EN defined: retired_cnt port present, increments by 1 on each RESP handshake with res_err = 0, wraps from all-ones to 0.
REQ-020 Macro ALU_SEQ_PERF_EN undefined: retired_cnt port and counter absent; all other behaviour identical.

Verification
REQ-021 Reset then instr=0x00221820 (rs=1, rt=2, rd=3, funct=0x20), alu_result=0x0000_0005 -> rf_we pulse 3 cycles after handshake with rf_waddr=3, rf_wdata=5; res_valid 4 cycles after, res_data=5, res_err=0.
REQ-022 instr with rd=0, alu_result=0xFFFF_FFFF, alu_carry=1 -> rf_we never asserted; res_data=0xFFFF_FFFF, res_carry=1.
REQ-023 instr=0x8C221820 (opcode 100011) -> res_err=1, res_data=0, rf_we never asserted, retired_cnt unchanged.
REQ-024 res_ready held 0 for 10 cycles in RESP -> res_valid and record stable, instr_ready=0, second instr_valid not accepted; res_ready=1 -> IDLE next cycle.
REQ-025 rst_n pulsed low during WB -> rf_we falls without clock edge, no res_valid, instr_ready=1 after release.
REQ-026 ALU_SEQ_PERF_EN with CNT_W=4: 17 valid instructions retired -> retired_cnt=1.
